sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 3, meaning the number of consecutive lost conflicts port I tolerates before it wins.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_req/i_addr  in  1/32  instruction-fetch read request and byte address.
REQ-005 i_gnt/i_rvalid/i_rdata  out  1/1/32  fetch grant, read-data valid, read data.
REQ-006 d_req/d_we/d_be/d_addr/d_wdata  in  1/1/4/32/32  data request, write enable, active-high byte enables, address, write data.
REQ-007 d_gnt/d_rvalid/d_rdata  out  1/1/32  data grant, read-data valid, read data.
REQ-008 sram_cen/sram_wen/sram_ben/sram_addr/sram_din  out  1/1/4/32/32  single-port SRAM controls, all active-low except addr/din.
REQ-009 sram_dout  in  32  SRAM read data, valid the cycle after a read access with sram_cen=0.

Function
REQ-010 Grants SHALL be combinational in the request cycle; at most one of i_gnt/d_gnt high per cycle.
REQ-011 Only one requester active: that requester SHALL be granted.
REQ-012 Conflict, default: D SHALL win unless starve_cnt==STARVE_MAX, in which case I wins.
REQ-013 starve_cnt (register) SHALL increment, saturating at STARVE_MAX, when i_req && !i_gnt; it SHALL clear when i_gnt is high or i_req is low.
REQ-014 A granted I access SHALL drive sram_cen=0, sram_wen=1, sram_ben=4'h0, sram_addr=i_addr.
REQ-015 A granted D read SHALL drive sram_cen=0, sram_wen=1, sram_ben=4'h0, sram_addr=d_addr.
REQ-016 A granted D write SHALL drive sram_cen=0, sram_wen=0, sram_ben=~d_be, sram_addr=d_addr, sram_din=d_wdata.
REQ-017 d_be=4'h0 write SHALL still be granted with sram_ben=4'hF, so no bytes are modified.
REQ-018 No grant: sram_cen=1, sram_wen=1, sram_ben=4'hF, sram_addr=0, sram_din=0.
REQ-019 Response owner register resp_own SHALL take one of NONE, I, D; it is set to I or D on a granted read and to NONE otherwise.
REQ-020 i_rvalid SHALL be high exactly when resp_own==I, and d_rvalid exactly when resp_own==D; read latency is 1 cycle from grant.
REQ-021 i_rdata/d_rdata SHALL equal sram_dout while the matching rvalid is high, and 0 otherwise.
REQ-022 Writes SHALL produce no rvalid.
REQ-023 Back-to-back grants SHALL be allowed every cycle, giving full throughput with a response overlapping the next access.
REQ-024 Requesters SHALL hold req/addr/data stable until grant; the block does not latch ungranted requests.

Reset
REQ-025 While rst=1, the block SHALL force: i_gnt=d_gnt=0, sram idle values per REQ-018, resp_own=NONE, starve_cnt=0, last_win=I.
REQ-026 In the first cycle after rst deasserts, i_rvalid and d_rvalid SHALL be 0; a read granted in the cycle rst asserts is dropped.

Configuration
REQ-027 With SRAM_ARB_RR_EN defined, a conflict SHALL be granted to the port opposite last_win, which updates on every conflict; starve_cnt and STARVE_MAX SHALL have no effect.
REQ-028 Without SRAM_ARB_RR_EN, arbitration SHALL follow REQ-012/REQ-013, and last_win is not implemented.

Verification
REQ-029 I read 0x100 alone, SRAM word 0x100 = 0xDEADBEEF -> i_gnt same cycle, i_rvalid=1 and i_rdata=0xDEADBEEF next cycle, d_rvalid=0.
REQ-030 D write 0x40, d_be=4'b0101, d_wdata=0x11223344 over 0xAAAAAAAA, then D read 0x40 -> d_rdata=0xAA22AA44.
REQ-031 Default config, i_req and d_req held high continuously -> grant pattern D,D,D,I repeating; i_gnt every 4th cycle.
REQ-032 SRAM_ARB_RR_EN config, continuous conflict -> grants alternate D,I,D,I starting with D after reset (last_win=I).
REQ-033 rst asserted in the cycle a D read is granted -> d_rvalid=0 in the following cycles; sram_cen=1 while rst=1.
REQ-034 D write with d_be=0 to 0x80 holding 0x12345678 -> d_gnt=1, sram_ben=4'hF, a later read returns 0x12345678.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port (instruction fetch / data) arbiter onto a single-port
//            SRAM with combinational grant and 1-cycle read response routing.
//            Optional macro SRAM_ARB_RR_EN selects round-robin conflict
//            resolution instead of the starvation-counter scheme.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [3:0]  sram_ben,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_din,
    input  logic [31:0] sram_dout
);

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_I    = 2'd1;
    localparam logic [1:0] c_OWN_D    = 2'd2;

    logic       w_conflict;
    logic       w_i_wins;
    logic [1:0] r_resp_own;

    assign w_conflict = i_req & d_req;

`ifdef SRAM_ARB_RR_EN
    // r_last_win: 0 = I won the previous conflict, 1 = D won it
    logic r_last_win;

    assign w_i_wins = r_last_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_win <= 1'b0;
        end else if (w_conflict) begin
            r_last_win <= ~w_i_wins;
        end
    end
`else
    localparam int                 c_CNT_W      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_i_wins = (r_starve_cnt == c_STARVE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`endif

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && (!w_conflict || w_i_wins)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_ben  = 4'hF;
        sram_addr = 32'h0;
        sram_din  = 32'h0;
        if (i_gnt) begin
            sram_cen  = 1'b0;
            sram_ben  = 4'h0;
            sram_addr = i_addr;
        end else if (d_gnt) begin
            sram_cen  = 1'b0;
            sram_addr = d_addr;
            if (d_we) begin
                // A zero byte-enable write still occupies the port but masks every byte
                sram_wen = 1'b0;
                sram_ben = ~d_be;
                sram_din = d_wdata;
            end else begin
                sram_ben = 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_own <= c_OWN_NONE;
        end else if (i_gnt) begin
            r_resp_own <= c_OWN_I;
        end else if (d_gnt && !d_we) begin
            r_resp_own <= c_OWN_D;
        end else begin
            r_resp_own <= c_OWN_NONE;
        end
    end

    assign i_rvalid = (r_resp_own == c_OWN_I);
    assign d_rvalid = (r_resp_own == c_OWN_D);
    assign i_rdata  = i_rvalid ? sram_dout : 32'h0;
    assign d_rdata  = d_rvalid ? sram_dout : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Directed self-checking bench for sram_arbiter with a behavioural
//            byte-masked SRAM model. Honours SRAM_ARB_RR_EN for expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_cen;
    logic        sram_wen;
    logic [3:0]  sram_ben;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural single-port SRAM, active-low controls, 1-cycle read latency
    logic [31:0] mem [0:255];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] din,
                                          input logic [3:0] ben_n);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (!ben_n[b]) r[b*8 +: 8] = din[b*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr[9:2]] <= merge(mem[sram_addr[9:2]], sram_din, sram_ben);
            else           sram_dout <= mem[sram_addr[9:2]];
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] dw);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_be = be; d_addr = da; d_wdata = dw;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] w);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, a, w);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        #1;
        n_checks++; if ({i_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {i_gnt, d_gnt}); end
        n_checks++; if ({sram_cen, sram_wen, sram_ben} !== 6'b11_1111) begin n_fail++; $display("FAIL reset_ctl: got %b want 111111", {sram_cen, sram_wen, sram_ben}); end
        n_checks++; if ({sram_addr, sram_din} !== 64'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", {sram_addr, sram_din}); end
        @(posedge clk); #1;
        n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {i_rvalid, d_rvalid}); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_checks++; if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin n_fail++; $display("FAIL post_reset_resp: got %b/%b %h %h want 0", i_rvalid, d_rvalid, i_rdata, d_rdata); end
    endtask

    task automatic test_i_read();
        do_write(32'h100, 32'hDEADBEEF);
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        n_checks++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL iread_gnt: got %b want 10", {i_gnt, d_gnt}); end
        n_checks++; if ({sram_cen, sram_wen, sram_ben, sram_addr} !== {1'b0, 1'b1, 4'h0, 32'h100}) begin n_fail++; $display("FAIL iread_ctl: got %b %b %h %h want 0 1 0 100", sram_cen, sram_wen, sram_ben, sram_addr); end
        @(posedge clk); #1;
        n_checks++; if ({i_rvalid, i_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL iread_resp: got %b %h want 1 deadbeef", i_rvalid, i_rdata); end
        n_checks++; if ({d_rvalid, d_rdata} !== 33'h0) begin n_fail++; $display("FAIL iread_dside: got %b %h want 0 0", d_rvalid, d_rdata); end
        idle_cycle();
        n_checks++; if ({i_rvalid, i_rdata} !== 33'h0) begin n_fail++; $display("FAIL iread_idle: got %b %h want 0 0", i_rvalid, i_rdata); end
    endtask

    task automatic test_d_byte_write();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hAAAAAAAA);
        #1;
        n_checks++; if ({i_gnt, d_gnt, sram_cen, sram_wen, sram_ben} !== {4'b0100, 4'h0}) begin n_fail++; $display("FAIL dwr_ctl: got %b%b%b%b %h want 0100 0", i_gnt, d_gnt, sram_cen, sram_wen, sram_ben); end
        n_checks++; if ({sram_addr, sram_din} !== {32'h40, 32'hAAAAAAAA}) begin n_fail++; $display("FAIL dwr_bus: got %h %h want 40 aaaaaaaa", sram_addr, sram_din); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h40, 32'h11223344);
        #1;
        n_checks++; if ({d_gnt, sram_wen, sram_ben} !== {1'b1, 1'b0, 4'b1010}) begin n_fail++; $display("FAIL dwr_be: got %b %b %b want 1 0 1010", d_gnt, sram_wen, sram_ben); end
        @(posedge clk); #1;
        n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL dwr_norvalid: got %b want 00", {i_rvalid, d_rvalid}); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        #1;
        n_checks++; if ({d_gnt, sram_cen, sram_wen, sram_ben} !== {3'b101, 4'h0}) begin n_fail++; $display("FAIL drd_ctl: got %b%b%b %h want 101 0", d_gnt, sram_cen, sram_wen, sram_ben); end
        @(posedge clk); #1;
        n_checks++; if ({d_rvalid, d_rdata, i_rvalid} !== {1'b1, 32'hAA22AA44, 1'b0}) begin n_fail++; $display("FAIL drd_resp: got %b %h %b want 1 aa22aa44 0", d_rvalid, d_rdata, i_rvalid); end
        idle_cycle();
    endtask

    task automatic test_be_zero();
        do_write(32'h80, 32'h12345678);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF);
        #1;
        n_checks++; if ({d_gnt, sram_cen, sram_wen, sram_ben} !== {3'b100, 4'hF}) begin n_fail++; $display("FAIL be0_ctl: got %b%b%b %h want 100 f", d_gnt, sram_cen, sram_wen, sram_ben); end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        @(posedge clk); #1;
        n_checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL be0_read: got %b %h want 1 12345678", d_rvalid, d_rdata); end
        idle_cycle();
    endtask

    task automatic test_conflict();
        logic exp_d [8];
`ifdef SRAM_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        idle_cycle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
            #1;
            n_checks++;
            if ({i_gnt, d_gnt, sram_addr} !== {!exp_d[k], exp_d[k], (exp_d[k] ? 32'h40 : 32'h100)}) begin
                n_fail++; $display("FAIL conflict_gnt[%0d]: got i=%b d=%b addr=%h want d=%b", k, i_gnt, d_gnt, sram_addr, exp_d[k]);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !==
                {!exp_d[k], exp_d[k], (exp_d[k] ? 32'h0 : 32'hDEADBEEF), (exp_d[k] ? 32'hAA22AA44 : 32'h0)}) begin
                n_fail++; $display("FAIL conflict_resp[%0d]: got %b%b %h %h want d=%b", k, i_rvalid, d_rvalid, i_rdata, d_rdata, exp_d[k]);
            end
        end
        idle_cycle();
    endtask

`ifndef SRAM_ARB_RR_EN
    task automatic test_starve_clear();
        logic exp_d [7];
        logic ir [7];
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ir    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(ir[k], 32'h100, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
            #1;
            n_checks++;
            if ({i_gnt, d_gnt} !== {!exp_d[k], exp_d[k]}) begin
                n_fail++; $display("FAIL starve_clear[%0d]: got i=%b d=%b want d=%b", k, i_gnt, d_gnt, exp_d[k]);
            end
            @(posedge clk);
        end
        idle_cycle();
    endtask
`endif

    task automatic test_reset_drop();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        #1;
        n_checks++; if ({d_gnt, sram_cen} !== 2'b01) begin n_fail++; $display("FAIL rstdrop_ctl: got gnt=%b cen=%b want 0 1", d_gnt, sram_cen); end
        @(posedge clk); #1;
        n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstdrop_rv0: got %b want 0", d_rvalid); end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstdrop_rv1: got %b want 00", {i_rvalid, d_rvalid}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_i_read();
        test_d_byte_write();
        test_be_zero();
        test_conflict();
`ifndef SRAM_ARB_RR_EN
        test_starve_clear();
`endif
        test_reset_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
